decoder_scan_sequencer: RTL

Upstream driver for the 4-to-16 decoder stage. It sweeps a 4-bit channel select across the set bits of a 16-bit channel mask, holding each channel for a programmable dwell time. It asserts the decoder enable only while a channel is active. It supports single-sweep and continuous modes, with start/stop control and done/wrap status pulses. Its outputs `sel` and `en` connect directly to the decoder's `in[3:0]` and `en`.

---
 rtl/decoder_scan_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - sweeps a 4-to-16 decoder select across the set bits of a channel mask
module decoder_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [15:0]        mask,
  output logic [3:0]         sel,
  output logic               en,
  output logic               busy,
  output logic               done,
  output logic               wrap
);

  typedef enum logic {S_IDLE = 1'b0, S_DWELL = 1'b1} state_t;

  localparam logic [DWELL_W-1:0] ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

  state_t             r_state, w_state_nxt;
  logic [DWELL_W-1:0] r_cnt, r_dwell_q, w_cnt_nxt, w_dwell_eff;
  logic [15:0]        r_mask_q;
  logic               r_mode_q;
  logic [3:0]         r_sel, w_sel_nxt;
  logic               r_busy, r_done, r_wrap, w_done_nxt, w_wrap_nxt;
  logic [4:0]         w_lo_new, w_nx_q;
  logic               w_accept, w_end, w_adv, w_wrap_ok, w_latch;

  // {found, index} of the lowest set bit of m at or above position lo
  function automatic logic [4:0] next_bit(input logic [15:0] m, input logic [4:0] lo);
    logic [4:0] res;
    res = 5'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i] && (5'(i) >= lo)) res = {1'b1, 4'(i)};
    end
    return res;
  endfunction

  assign w_dwell_eff = (dwell == '0) ? ONE : dwell;
  assign w_lo_new    = next_bit(mask, 5'd0);
  assign w_nx_q      = next_bit(r_mask_q, {1'b0, r_sel} + 5'd1);
  assign w_accept    = (r_state == S_IDLE) && start && !stop;
  assign w_end       = (r_state == S_DWELL) && !stop && (r_cnt == '0);
  assign w_adv       = w_end && w_nx_q[4];
  assign w_wrap_ok   = w_end && !w_nx_q[4] && r_mode_q;
  assign w_latch     = w_accept || w_wrap_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_dwell_q <= '0;
      r_mask_q  <= '0;
      r_mode_q  <= 1'b0;
      r_sel     <= 4'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
      r_busy  <= (w_state_nxt == S_DWELL);
      r_done  <= w_done_nxt;
      r_wrap  <= w_wrap_nxt;
      if (w_latch) begin
        r_dwell_q <= w_dwell_eff;
        r_mask_q  <= mask;
        r_mode_q  <= mode;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept && w_lo_new[4]) w_state_nxt = S_DWELL;
      end
      S_DWELL: begin
        if (stop) w_state_nxt = S_IDLE;
        else if (w_end && !w_adv && !(w_wrap_ok && w_lo_new[4])) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_sel_nxt  = r_sel;
    w_cnt_nxt  = r_cnt;
    w_done_nxt = 1'b0;
    w_wrap_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_lo_new[4]) begin
            w_sel_nxt = w_lo_new[3:0];
            w_cnt_nxt = w_dwell_eff - ONE;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      S_DWELL: begin
        if (stop) begin
          w_sel_nxt = 4'd0;
          w_cnt_nxt = '0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - ONE;
        end else if (w_adv) begin
          w_sel_nxt = w_nx_q[3:0];
          w_cnt_nxt = r_dwell_q - ONE;
        end else if (r_mode_q && w_lo_new[4]) begin
          // Continuous restart uses the freshly latched mask and dwell
          w_wrap_nxt = 1'b1;
          w_sel_nxt  = w_lo_new[3:0];
          w_cnt_nxt  = w_dwell_eff - ONE;
        end else begin
          w_done_nxt = 1'b1;
          w_sel_nxt  = 4'd0;
        end
      end
      default: w_sel_nxt = 4'd0;
    endcase
  end

  assign sel  = r_sel;
  assign en   = r_busy;
  assign busy = r_busy;
  assign done = r_done;
  assign wrap = r_wrap;

endmodule
